// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Command-side initiator for the combinational ALU. Accepts one request at a
//   time over a valid/ready channel, registers it onto the alu_* ports, captures
//   the ALU result/carry one cycle later and queues a tagged response in a small
//   in-order FIFO. Upstream and downstream backpressure never reach the ALU.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready   request handshake; cmd_opcode, cmd_a, cmd_b, cmd_shift,
//                     cmd_tag form the request payload
//   alu_opcode, alu_input1, alu_input2, alu_shift_value
//                     registered operation driven to the ALU
//   alu_result, alu_carry
//                     combinational ALU outputs, sampled at the end of ISSUE
//   rsp_valid/ready   response handshake; rsp_result, rsp_carry, rsp_illegal,
//                     rsp_tag reflect the FIFO head
module alu_cmd_sequencer #(
  parameter int unsigned WIDTH     = 128,
  parameter int unsigned SHIFT_W   = 5,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_opcode,
  input  logic [WIDTH-1:0]   cmd_a,
  input  logic [WIDTH-1:0]   cmd_b,
  input  logic [SHIFT_W-1:0] cmd_shift,
  input  logic [TAG_W-1:0]   cmd_tag,
  output logic [3:0]         alu_opcode,
  output logic [WIDTH-1:0]   alu_input1,
  output logic [WIDTH-1:0]   alu_input2,
  output logic [SHIFT_W-1:0] alu_shift_value,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_carry,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic               rsp_carry,
  output logic               rsp_illegal,
  output logic [TAG_W-1:0]   rsp_tag
);

  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(RSP_DEPTH);

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_SLL = 4'd4
  } opcode_t;

  state_t state, state_next;

  logic [TAG_W-1:0] tag_q;
  logic             illegal_q;
  logic             accept;
  logic             push;
  logic             pop;
  logic             cmd_legal;
  logic             carry_in;

  logic [WIDTH-1:0] mem_result  [RSP_DEPTH];
  logic             mem_carry   [RSP_DEPTH];
  logic             mem_illegal [RSP_DEPTH];
  logic [TAG_W-1:0] mem_tag     [RSP_DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs. ready depends only on registered state and count, so no
  // combinational path exists from cmd_* or rsp_ready to any output.
  always_comb begin
    cmd_ready = 1'b0;
    push      = 1'b0;
    unique case (state)
      IDLE:    cmd_ready = (count < FULL_COUNT);
      ISSUE:   push      = 1'b1;
      default: ;
    endcase
  end

  assign accept    = cmd_valid && cmd_ready;
  assign pop       = rsp_valid && rsp_ready;
  assign cmd_legal = (cmd_opcode <= OP_SLL);

  // ---------------------------------------------------------------------------
  // Issue registers: hold their last values while IDLE. Illegal requests drive
  // a harmless all-zero operation so the ALU never sees an undefined opcode.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode      <= '0;
      alu_input1      <= '0;
      alu_input2      <= '0;
      alu_shift_value <= '0;
      tag_q           <= '0;
      illegal_q       <= 1'b0;
    end else if (accept) begin
      tag_q     <= cmd_tag;
      illegal_q <= !cmd_legal;
      if (cmd_legal) begin
        alu_opcode      <= cmd_opcode;
        alu_input1      <= cmd_a;
        alu_input2      <= cmd_b;
        alu_shift_value <= cmd_shift;
      end else begin
        alu_opcode      <= '0;
        alu_input1      <= '0;
        alu_input2      <= '0;
        alu_shift_value <= '0;
      end
    end
  end

  // Carry is meaningful only for ADD/SUB; an illegal request also decodes as
  // opcode 0 on the ALU port, so the illegal flag must mask it explicitly.
  assign carry_in = !illegal_q &&
                    ((alu_opcode == OP_ADD) || (alu_opcode == OP_SUB)) &&
                    alu_carry;

  // ---------------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wr_ptr]  <= illegal_q ? '0 : alu_result;
      mem_carry[wr_ptr]   <= carry_in;
      mem_illegal[wr_ptr] <= illegal_q;
      mem_tag[wr_ptr]     <= tag_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W + 1)'(1);
      else if (pop && !push) count <= count - (PTR_W + 1)'(1);
    end
  end

  // Storage is not reset; gating with rsp_valid keeps rsp_* at zero when empty.
  assign rsp_valid   = (count != '0);
  assign rsp_result  = rsp_valid ? mem_result[rd_ptr]  : '0;
  assign rsp_carry   = rsp_valid ? mem_carry[rd_ptr]   : 1'b0;
  assign rsp_illegal = rsp_valid ? mem_illegal[rd_ptr] : 1'b0;
  assign rsp_tag     = rsp_valid ? mem_tag[rd_ptr]     : '0;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer
//   Directed self-checking bench for alu_cmd_sequencer with a behavioural
//   128-bit ALU attached to the alu_* ports.
module tb_alu_cmd_sequencer;

  localparam int unsigned WIDTH     = 128;
  localparam int unsigned SHIFT_W   = 5;
  localparam int unsigned TAG_W     = 4;
  localparam int unsigned RSP_DEPTH = 4;

  logic               clk;
  logic               rst_n;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [3:0]         cmd_opcode;
  logic [WIDTH-1:0]   cmd_a;
  logic [WIDTH-1:0]   cmd_b;
  logic [SHIFT_W-1:0] cmd_shift;
  logic [TAG_W-1:0]   cmd_tag;
  logic [3:0]         alu_opcode;
  logic [WIDTH-1:0]   alu_input1;
  logic [WIDTH-1:0]   alu_input2;
  logic [SHIFT_W-1:0] alu_shift_value;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_carry;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_result;
  logic               rsp_carry;
  logic               rsp_illegal;
  logic [TAG_W-1:0]   rsp_tag;

  int checks;
  int errors;

  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  alu_cmd_sequencer #(
    .WIDTH    (WIDTH),
    .SHIFT_W  (SHIFT_W),
    .TAG_W    (TAG_W),
    .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_opcode     (cmd_opcode),
    .cmd_a          (cmd_a),
    .cmd_b          (cmd_b),
    .cmd_shift      (cmd_shift),
    .cmd_tag        (cmd_tag),
    .alu_opcode     (alu_opcode),
    .alu_input1     (alu_input1),
    .alu_input2     (alu_input2),
    .alu_shift_value(alu_shift_value),
    .alu_result     (alu_result),
    .alu_carry      (alu_carry),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_result     (rsp_result),
    .rsp_carry      (rsp_carry),
    .rsp_illegal    (rsp_illegal),
    .rsp_tag        (rsp_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: SUB reports borrow as carry; AND/OR/SLL report carry 0.
  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    case (alu_opcode)
      4'd0: {alu_carry, alu_result} = {1'b0, alu_input1} + {1'b0, alu_input2};
      4'd1: begin
        alu_result = alu_input1 - alu_input2;
        alu_carry  = (alu_input1 < alu_input2);
      end
      4'd2: alu_result = alu_input1 & alu_input2;
      4'd3: alu_result = alu_input1 | alu_input2;
      4'd4: alu_result = alu_input1 << alu_shift_value;
      default: alu_result = ONES;
    endcase
  end

  // Presents a request starting #1 after a rising edge and holds it until the
  // accepting edge; returns #1 after that edge with cmd_valid low.
  task automatic send(input logic [3:0] op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic [SHIFT_W-1:0] sh,
                      input logic [TAG_W-1:0] tag);
    bit done;
    done       = 1'b0;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    cmd_shift  = sh;
    cmd_tag    = tag;
    cmd_valid  = 1'b1;
    for (int n = 0; n < 30 && !done; n++) begin
      if (cmd_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout tag=%0d actual cmd_ready=%0b required 1", tag, cmd_ready);
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_opcode = '0;
    cmd_a      = '0;
    cmd_b      = '0;
    cmd_shift  = '0;
    cmd_tag    = '0;
    rsp_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready actual %0b required 1", cmd_ready);
    end
    checks++;
    if ({rsp_valid, rsp_carry, rsp_illegal, rsp_tag, rsp_result} !== '0) begin
      errors++; $display("FAIL reset_rsp actual v=%0b r=%h required all 0", rsp_valid, rsp_result);
    end
    checks++;
    if ({alu_opcode, alu_input1, alu_input2, alu_shift_value} !== '0) begin
      errors++; $display("FAIL reset_alu actual op=%0d in1=%h required all 0", alu_opcode, alu_input1);
    end
  endtask

  task automatic test_add();
    rsp_ready = 1'b1;
    send(4'd0, ONES, 128'd1, 5'd0, 4'd3);
    // cycle T+1: ISSUE
    checks++;
    if (alu_input1 !== ONES || alu_input2 !== 128'd1 || alu_opcode !== 4'd0) begin
      errors++; $display("FAIL add_alu_ports actual op=%0d in1=%h in2=%h required op=0 in1=all-ones in2=1",
                         alu_opcode, alu_input1, alu_input2);
    end
    checks++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL add_issue_cycle actual ready=%0b rsp_valid=%0b required 0 0", cmd_ready, rsp_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== '0 || rsp_carry !== 1'b1 ||
        rsp_illegal !== 1'b0 || rsp_tag !== 4'd3) begin
      errors++; $display("FAIL add_rsp actual v=%0b r=%h c=%0b i=%0b t=%0d required 1 0 1 0 3",
                         rsp_valid, rsp_result, rsp_carry, rsp_illegal, rsp_tag);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL add_ready_back actual %0b required 1", cmd_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL add_pop actual rsp_valid=%0b required 0", rsp_valid);
    end
  endtask

  task automatic test_sub_and();
    rsp_ready = 1'b1;
    send(4'd1, 128'd5, 128'd7, 5'd0, 4'd5);
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== {{(WIDTH-1){1'b1}}, 1'b0} ||
        rsp_carry !== 1'b1 || rsp_tag !== 4'd5) begin
      errors++; $display("FAIL sub_rsp actual v=%0b r=%h c=%0b t=%0d required 1 ff..fe 1 5",
                         rsp_valid, rsp_result, rsp_carry, rsp_tag);
    end
    send(4'd2, 128'hF0, 128'h3C, 5'd0, 4'd6);
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 128'h30 || rsp_carry !== 1'b0 ||
        rsp_tag !== 4'd6) begin
      errors++; $display("FAIL and_rsp actual v=%0b r=%h c=%0b t=%0d required 1 30 0 6",
                         rsp_valid, rsp_result, rsp_carry, rsp_tag);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sll();
    rsp_ready = 1'b1;
    send(4'd4, 128'd1, 128'd0, 5'd31, 4'd9);
    checks++;
    if (alu_shift_value !== 5'd31 || alu_opcode !== 4'd4) begin
      errors++; $display("FAIL sll_alu_ports actual sh=%0d op=%0d required 31 4", alu_shift_value, alu_opcode);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 128'h8000_0000 || rsp_carry !== 1'b0 ||
        rsp_tag !== 4'd9) begin
      errors++; $display("FAIL sll_rsp actual v=%0b r=%h c=%0b t=%0d required 1 80000000 0 9",
                         rsp_valid, rsp_result, rsp_carry, rsp_tag);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    rsp_ready = 1'b1;
    send(4'd9, ONES, ONES, 5'd7, 4'd12);
    checks++;
    if (alu_input1 !== '0 || alu_input2 !== '0 || alu_opcode !== 4'd0) begin
      errors++; $display("FAIL illegal_alu_ports actual op=%0d in1=%h in2=%h required 0 0 0",
                         alu_opcode, alu_input1, alu_input2);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== '0 || rsp_carry !== 1'b0 ||
        rsp_illegal !== 1'b1 || rsp_tag !== 4'd12) begin
      errors++; $display("FAIL illegal_rsp actual v=%0b r=%h c=%0b i=%0b t=%0d required 1 0 0 1 12",
                         rsp_valid, rsp_result, rsp_carry, rsp_illegal, rsp_tag);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b0;
    // ADD tag+0 so each result equals 100+tag and identifies the entry.
    for (int t = 0; t < 4; t++) begin
      send(4'd0, 128'(100 + t), 128'd0, 5'd0, 4'(t));
      @(posedge clk); #1;
    end
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL full_ready actual %0b required 0", cmd_ready);
    end
    // Present the 5th request; it must not be accepted while full.
    cmd_opcode = 4'd0; cmd_a = 128'd104; cmd_b = '0; cmd_shift = '0; cmd_tag = 4'd4;
    cmd_valid  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b0 || alu_input1 !== 128'd103 || rsp_tag !== 4'd0) begin
      errors++; $display("FAIL full_hold actual ready=%0b in1=%0d head=%0d required 0 103 0",
                         cmd_ready, alu_input1, rsp_tag);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;            // pop tag 0
    checks++;
    if (rsp_tag !== 4'd1 || rsp_result !== 128'd101 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL drain_1 actual tag=%0d r=%0d ready=%0b required 1 101 1",
                         rsp_tag, rsp_result, cmd_ready);
    end
    @(posedge clk); #1;            // pop tag 1, accept tag 4
    cmd_valid = 1'b0;
    checks++;
    if (rsp_tag !== 4'd2 || cmd_ready !== 1'b0 || alu_input1 !== 128'd104) begin
      errors++; $display("FAIL drain_2 actual tag=%0d ready=%0b in1=%0d required 2 0 104",
                         rsp_tag, cmd_ready, alu_input1);
    end
    @(posedge clk); #1;            // pop tag 2, push tag 4
    checks++;
    if (rsp_tag !== 4'd3 || rsp_result !== 128'd103) begin
      errors++; $display("FAIL drain_3 actual tag=%0d r=%0d required 3 103", rsp_tag, rsp_result);
    end
    @(posedge clk); #1;            // pop tag 3
    checks++;
    if (rsp_valid !== 1'b1 || rsp_tag !== 4'd4 || rsp_result !== 128'd104) begin
      errors++; $display("FAIL drain_4 actual v=%0b tag=%0d r=%0d required 1 4 104",
                         rsp_valid, rsp_tag, rsp_result);
    end
    @(posedge clk); #1;            // pop tag 4
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL drain_empty actual rsp_valid=%0b required 0", rsp_valid);
    end
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    rsp_ready = 1'b0;
    send(4'd3, 128'h1, 128'h2, 5'd0, 4'd1);
    @(posedge clk); #1;
    send(4'd3, 128'h4, 128'h8, 5'd0, 4'd2);
    @(posedge clk); #1;
    send(4'd0, 128'h55, 128'h1, 5'd3, 4'd7);
    // now in ISSUE with 2 entries queued
    checks++;
    if (rsp_valid !== 1'b1 || rsp_tag !== 4'd1 || rsp_result !== 128'h3) begin
      errors++; $display("FAIL pre_reset_head actual v=%0b tag=%0d r=%h required 1 1 3",
                         rsp_valid, rsp_tag, rsp_result);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, rsp_carry, rsp_illegal, rsp_tag, rsp_result} !== '0 ||
        {alu_opcode, alu_input1, alu_input2, alu_shift_value} !== '0) begin
      errors++; $display("FAIL midreset_outputs actual v=%0b tag=%0d in1=%h required all 0",
                         rsp_valid, rsp_tag, alu_input1);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_ready actual %0b required 1", cmd_ready);
    end
    seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (rsp_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL midreset_no_rsp actual seen=%0b required 0", seen);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_sub_and();
    test_sll();
    test_illegal();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual time=%0t required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
